// File: rtl/pdm_audio_pkg.sv
// Shared types and constants for the PCM-to-PDM audio transmitter.
package pdm_audio_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic signed [DATA_W_DEF-1:0] MIDSCALE = '0;

    // Signed two's complement to offset-binary: flip the sign bit.
    function automatic logic [DATA_W_DEF-1:0] to_offset(input logic signed [DATA_W_DEF-1:0] s);
        return {~s[DATA_W_DEF-1], s[DATA_W_DEF-2:0]};
    endfunction

endpackage

// File: rtl/pdm_audio_tx_tick_gen.sv
// PDM bit-rate divider: counts 0..CLK_DIV-1 while run is high, held at 0 otherwise.
module pdm_tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    // Combinational so the top can update ampPWM and pdm_tick on the same edge.
    assign tick = run && (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM transmitter: one-entry sample buffer, first-order sigma-delta
// modulator and OFF/WARM/RUN amplifier sequencing.
module pdm_audio_tx
    import pdm_audio_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CLK_DIV    = 50,
    parameter int OSR        = 64,
    parameter int WARM_TICKS = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] sample_data,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     ampPWM,
    output logic                     ampSD,
    output logic                     pdm_tick,
    output logic                     underrun,
    output state_t                   dbg_state
);

    localparam int OSR_W  = $clog2(OSR);
    localparam int WARM_W = (WARM_TICKS > 1) ? $clog2(WARM_TICKS) : 1;

    state_t            state, state_nx;
    logic              tick, run, accept, boundary, underrun_nx;
    logic              warm_last, smp_last, hold_full;
    logic [WARM_W-1:0] warm_cnt;
    logic [OSR_W-1:0]  smp_cnt;
    logic [DATA_W-1:0] acc, hold, active, u;

    // Handshake: a sample transfers on any edge where sample_valid and
    // sample_ready are both high; ready depends only on registered state.
    assign sample_ready = !hold_full && (state != ST_OFF);
    assign accept       = sample_valid && sample_ready;
    assign ampSD        = (state != ST_OFF);
    assign dbg_state    = state;

    // Stopping the divider on the shutdown edge keeps it at 0 throughout OFF.
    assign run = enable && (state != ST_OFF);

    pdm_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    assign u         = {~active[DATA_W-1], active[DATA_W-2:0]};
    assign warm_last = (warm_cnt == WARM_W'(WARM_TICKS - 1));
    assign smp_last  = (smp_cnt == OSR_W'(OSR - 1));

    always_comb begin
        state_nx    = state;
        boundary    = 1'b0;
        underrun_nx = 1'b0;
        case (state)
            ST_OFF: begin
                if (enable) state_nx = ST_WARM;
            end
            ST_WARM: begin
                if (!enable) begin
                    state_nx = ST_OFF;
                end else if (tick && warm_last) begin
                    state_nx = ST_RUN;
                    boundary = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_nx = ST_OFF;
                end else if (tick && smp_last) begin
                    boundary    = 1'b1;
                    underrun_nx = !hold_full;
                end
            end
            default: state_nx = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_OFF;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (state_nx == ST_OFF)) begin
            acc       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            active    <= '0;
            warm_cnt  <= '0;
            smp_cnt   <= '0;
            ampPWM    <= 1'b0;
            pdm_tick  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            pdm_tick <= tick;
            underrun <= underrun_nx;
            if (accept) begin
                hold      <= sample_data;
                hold_full <= 1'b1;
            end
            if (tick) begin
                {ampPWM, acc} <= {1'b0, acc} + {1'b0, u};
                if (state == ST_WARM) begin
                    warm_cnt <= warm_last ? '0 : warm_cnt + 1'b1;
                end else begin
                    smp_cnt <= smp_last ? '0 : smp_cnt + 1'b1;
                end
            end
            // Active stays at midscale through WARM; it only loads at a boundary.
            if (boundary && hold_full) begin
                active    <= hold;
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_audio_tx.sv
// Self-checking bench for pdm_audio_tx: tick-indexed reference model plus
// directed scenarios and randomized sample traffic.
module tb_pdm_audio_tx;
    import pdm_audio_pkg::*;

    localparam int DATA_W     = 16;
    localparam int CLK_DIV    = 4;
    localparam int OSR        = 8;
    localparam int WARM_TICKS = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic sample_valid = 1'b0;
    logic signed [DATA_W-1:0] sample_data = '0;
    logic sample_ready, ampPWM, ampSD, pdm_tick, underrun;
    state_t dbg_state;

    always #5 clk = ~clk;

    pdm_audio_tx #(
        .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .OSR(OSR), .WARM_TICKS(WARM_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .ampPWM(ampPWM), .ampSD(ampSD),
        .pdm_tick(pdm_tick), .underrun(underrun), .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Mode 0 = amp off, 1 = warm-up, 2 = playing. Ticks are numbered from the
    // moment the amp is enabled; sample windows are OSR ticks after warm-up.
    logic [DATA_W-1:0] exp_q[$];
    int   m_mode = 0, m_phase = 0, m_nticks = 0, m_acc = 0, m_active = 0;
    logic m_pwm = 1'b0, m_tick = 1'b0, m_under = 1'b0;

    always @(posedge clk) begin : p_model
        int   mu, sum;
        logic pre_ready, was_full;
        logic signed [DATA_W-1:0] popped;
        pre_ready = (m_mode != 0) && (exp_q.size() == 0);
        m_tick = 1'b0;
        m_under = 1'b0;
        if (reset) begin
            m_mode = 0; m_acc = 0; m_active = 0; m_pwm = 1'b0;
            m_phase = 0; m_nticks = 0; exp_q.delete();
        end else if (m_mode == 0) begin
            m_pwm = 1'b0;
            if (enable) begin
                m_mode = 1; m_phase = 0; m_nticks = 0;
            end
        end else if (!enable) begin
            m_mode = 0; m_acc = 0; m_active = 0; m_pwm = 1'b0; exp_q.delete();
        end else begin
            was_full = (exp_q.size() != 0);
            if (m_phase % CLK_DIV == CLK_DIV - 1) begin
                mu = m_active + 32768;
                sum = m_acc + mu;
                m_pwm = (sum >= 65536);
                m_acc = sum % 65536;
                m_tick = 1'b1;
                m_nticks++;
                if (m_mode == 1 && m_nticks == WARM_TICKS) begin
                    m_mode = 2;
                    if (was_full) begin
                        popped = exp_q.pop_front();
                        m_active = popped;
                    end
                end else if (m_mode == 2 && (m_nticks - WARM_TICKS) % OSR == 0) begin
                    if (was_full) begin
                        popped = exp_q.pop_front();
                        m_active = popped;
                    end else begin
                        m_under = 1'b1;
                    end
                end
            end
            if (sample_valid && pre_ready) exp_q.push_back(sample_data);
            m_phase++;
        end
    end

    // Per-cycle comparison plus a log of PDM bits for window-level checks.
    logic tick_log [0:255];
    int   nlog = 0;
    int   n_under = 0;

    always @(negedge clk) begin
        check("ampSD", 32'(ampSD), 32'(m_mode != 0));
        check("ampPWM", 32'(ampPWM), 32'(m_pwm));
        check("pdm_tick", 32'(pdm_tick), 32'(m_tick));
        check("underrun", 32'(underrun), 32'(m_under));
        check("sample_ready", 32'(sample_ready), 32'((m_mode != 0) && (exp_q.size() == 0)));
        if (pdm_tick && nlog < 256) begin
            tick_log[nlog] = ampPWM;
            nlog++;
        end
        if (underrun) n_under++;
    end

    function automatic int ones(input int lo, input int hi);
        int s = 0;
        for (int i = lo; i <= hi; i++) s += int'(tick_log[i]);
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ticks(input int n);
        int budget = 4000;
        while (nlog < n && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (nlog < n) check("tick_timeout", 32'(nlog), 32'(n));
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        bit ok = 0;
        sample_valid = 1'b1;
        sample_data = d;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (sample_ready) ok = 1;
        end
        @(posedge clk);
        #1 sample_valid = 1'b0;
        if (!ok) check("push_timeout", 32'(ok), 32'd1);
    endtask

    task automatic power_cycle();
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (4) @(posedge clk);
        #1 enable = 1'b1;
        nlog = 0;
        n_under = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int off_left;
        bit acc_now, found;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_state", 32'(dbg_state), 32'(ST_OFF));
        check("reset_sd", 32'(ampSD), 32'd0);
        nlog = 0;
        repeat (100) @(posedge clk);
        #1 check("no_tick_in_off", 32'(nlog), 32'd0);

        // Enable with no samples: midscale warm-up, then an underrun.
        enable = 1'b1;
        nlog = 0;
        n_under = 0;
        @(posedge clk);
        #1 check("sd_rise", 32'(ampSD), 32'd1);
        wait_ticks(WARM_TICKS + 1);
        check("no_underrun_warm", 32'(n_under), 32'd0);
        for (int i = 0; i < WARM_TICKS; i++) check("warm_bit", 32'(tick_log[i]), 32'(i % 2));
        wait_ticks(WARM_TICKS + OSR);
        check("first_underrun", 32'(n_under), 32'd1);

        // Full-scale negative then full-scale positive.
        power_cycle();
        push(16'h8000);
        push(16'h7FFF);
        wait_ticks(WARM_TICKS + 2 * OSR);
        check("neg_fullscale_ones", 32'(ones(WARM_TICKS, WARM_TICKS + OSR - 1)), 32'd0);
        check("pos_fullscale_ge7", 32'(ones(WARM_TICKS + OSR, WARM_TICKS + 2 * OSR - 1) >= 7), 32'd1);

        // Continuous 0x4000: 6 of 8 ones per window, no underrun.
        power_cycle();
        sample_data = 16'h4000;
        sample_valid = 1'b1;
        wait_ticks(WARM_TICKS + 5 * OSR);
        for (int w = 0; w < 5; w++)
            check("quarter_ones", 32'(ones(WARM_TICKS + w * OSR, WARM_TICKS + (w + 1) * OSR - 1)), 32'd6);
        check("no_underrun_stream", 32'(n_under), 32'd0);

        // Shut down with the hold full; the buffered sample must be dropped.
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (!sample_ready) found = 1;
        end
        check("hold_full_seen", 32'(found), 32'd1);
        @(posedge clk);
        #1 enable = 1'b0;
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        check("off_sd", 32'(ampSD), 32'd0);
        check("off_pwm", 32'(ampPWM), 32'd0);
        check("off_ready", 32'(sample_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
        nlog = 0;
        n_under = 0;
        wait_ticks(WARM_TICKS + OSR);
        check("old_sample_dropped", 32'(ones(WARM_TICKS, WARM_TICKS + OSR - 1)), 32'd4);
        check("reenable_underrun", 32'(n_under), 32'd1);

        // Randomized traffic with occasional shutdowns.
        off_left = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            acc_now = sample_valid && sample_ready;
            @(posedge clk);
            #1;
            if (acc_now) sample_valid = 1'b0;
            if (!sample_valid && $urandom_range(0, 3) == 0) begin
                sample_valid = 1'b1;
                case ($urandom_range(0, 3))
                    0: sample_data = 16'h8000;
                    1: sample_data = 16'h7FFF;
                    default: sample_data = DATA_W'($urandom);
                endcase
            end
            if (off_left > 0) begin
                off_left--;
                if (off_left == 0) enable = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                enable = 1'b0;
                off_left = $urandom_range(1, 5);
            end
        end
        sample_valid = 1'b0;
        enable = 1'b1;

        // Reset mid-RUN with enable held high.
        nlog = 0;
        wait_ticks(WARM_TICKS + 2);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_sd", 32'(ampSD), 32'd0);
        check("rst_pwm", 32'(ampPWM), 32'd0);
        check("rst_ready", 32'(sample_ready), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_OFF));
        @(posedge clk);
        #1;
        check("rst_rewarm_state", 32'(dbg_state), 32'(ST_WARM));
        check("rst_rewarm_sd", 32'(ampSD), 32'd1);
        repeat (20) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
